// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer: op encodings, FSM states,
// and the single-edge behavioural model of the JK latch.
package jk_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TOG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10
    } state_t;

    // Value the latch takes after one clock edge with {J,K} = op applied.
    function automatic logic next_exp(input logic [1:0] op, input logic cur);
        logic nxt;
        case (op)
            OP_HOLD: nxt = cur;
            OP_RST:  nxt = 1'b0;
            OP_SET:  nxt = 1'b1;
            OP_TOG:  nxt = ~cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous circular-buffer FIFO holding queued {op, len} commands.
// Read data is the current head entry; full/empty come from the registered
// occupancy count, so a slot freed by a pop is visible one cycle later.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == {(AW+1){1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_q[rd_ptr_q];

    // Next pointer/occupancy values; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok_s && !push_ok_s) begin
            count_d = count_q - 1'b1;
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the entry is not occupied.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/jk_cmd_seq.sv
// JK command sequencer: pops queued commands, drives registered J/K for
// len+1 cycles, then spends one CHECK cycle with J=K=0 comparing the latch
// feedback against the modelled latch output.
module jk_cmd_seq
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             J,
    output logic             K,
    input  logic             q,
    output logic             busy,
    output logic             exp_q,
    output logic             done,
    output logic             mismatch
);

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               j_q, j_d;
    logic               k_q, k_d;
    logic               model_q, model_d;
    logic               done_q, done_d;
    logic               mm_q, mm_d;

    logic               push_s, pop_s;
    logic               full_s, empty_s;
    logic [CNT_W+1:0]   head_s;
    logic [1:0]         head_op_s;
    logic [CNT_W-1:0]   head_len_s;

    assign push_s     = cmd_valid & ~full_s;
    assign head_op_s  = head_s[CNT_W+1:CNT_W];
    assign head_len_s = head_s[CNT_W-1:0];

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CNT_W + 2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({cmd_op, cmd_len}),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next-state, counter, J/K drive and latch-model update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        model_d = model_q;
        done_d  = 1'b0;
        mm_d    = mm_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    op_d    = head_op_s;
                    cnt_d   = head_len_s;
                    j_d     = head_op_s[1];
                    k_d     = head_op_s[0];
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                // The latch sees {J,K}=op on this edge, so the model steps too.
                model_d = next_exp(op_q, model_q);
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    j_d     = op_q[1];
                    k_d     = op_q[0];
                    state_d = ST_DRIVE;
                end
            end
            ST_CHECK: begin
                done_d = 1'b1;
                if (q != model_q) begin
                    mm_d = 1'b1;
                end else begin
                    mm_d = mm_q;
                end
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    op_d    = head_op_s;
                    cnt_d   = head_len_s;
                    j_d     = head_op_s[1];
                    k_d     = head_op_s[0];
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= {CNT_W{1'b0}};
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            model_q <= 1'b0;
            done_q  <= 1'b0;
            mm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            model_q <= model_d;
            done_q  <= done_d;
            mm_q    <= mm_d;
        end
    end

    assign cmd_ready = ~full_s;
    assign J         = j_q;
    assign K         = k_q;
    assign exp_q     = model_q;
    assign done      = done_q;
    assign mismatch  = mm_q;
    assign busy      = (state_q != ST_IDLE) | ~empty_s;

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Directed self-checking bench for jk_cmd_seq with a behavioural JK latch
// closing the q feedback loop.
module tb_jk_cmd_seq;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_len;
    logic             J;
    logic             K;
    logic             q;
    logic             busy;
    logic             exp_q;
    logic             done;
    logic             mismatch;

    logic             latch_q;
    logic             force_q0;

    int checks = 0;
    int errors = 0;

    jk_cmd_seq #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .J         (J),
        .K         (K),
        .q         (q),
        .busy      (busy),
        .exp_q     (exp_q),
        .done      (done),
        .mismatch  (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural JK latch, reset together with the sequencer.
    always @(posedge clk) begin
        if (rst) begin
            latch_q <= 1'b0;
        end else begin
            case ({J, K})
                2'b01:   latch_q <= 1'b0;
                2'b10:   latch_q <= 1'b1;
                2'b11:   latch_q <= ~latch_q;
                default: latch_q <= latch_q;
            endcase
        end
    end

    assign q = force_q0 ? 1'b0 : latch_q;

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({J, K} !== 2'b00) begin errors++; $display("FAIL reset_jk got %b want 00", {J, K}); end
        checks++; if (exp_q !== 1'b0) begin errors++; $display("FAIL reset_exp_q got %b want 0", exp_q); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %b want 0", mismatch); end
        rst = 1'b0; cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0 || {J, K} !== 2'b00) begin
                errors++; $display("FAIL reset_nothing_queued cyc %0d busy %b jk %b want 0 00", c, busy, {J, K});
            end
        end
    endtask

    // One command from idle: checks the full J/K/done timeline.
    task automatic test_single(input string name, input logic [1:0] op, input logic [3:0] len,
                               input logic exp_end, input logic mm_exp);
        logic [1:0] want_jk;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got %b want 1", name, cmd_ready); end
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c <= int'(len) + 4; c++) begin
            @(negedge clk);
            want_jk = (c >= 1 && c <= int'(len) + 1) ? op : 2'b00;
            checks++; if ({J, K} !== want_jk) begin
                errors++; $display("FAIL %s_jk cyc %0d got %b want %b", name, c, {J, K}, want_jk);
            end
            checks++; if (done !== (c == int'(len) + 3)) begin
                errors++; $display("FAIL %s_done cyc %0d got %b want %b", name, c, done, (c == int'(len) + 3));
            end
            if (c == int'(len) + 3) begin
                checks++; if (exp_q !== exp_end) begin errors++; $display("FAIL %s_exp_q got %b want %b", name, exp_q, exp_end); end
                checks++; if (mismatch !== mm_exp) begin errors++; $display("FAIL %s_mismatch got %b want %b", name, mismatch, mm_exp); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %b want 0", name, busy); end
    endtask

    task automatic test_toggle();
        test_single("clear", 2'b01, 4'd0, 1'b0, 1'b0);
        test_single("tog_len2", 2'b11, 4'd2, 1'b1, 1'b0);
        test_single("tog_len1", 2'b11, 4'd1, 1'b1, 1'b0);
    endtask

    // Six commands pushed back to back: fills the FIFO behind a driving command.
    task automatic test_full_fifo();
        logic [1:0] ops [6];
        logic [3:0] lens [6];
        logic [1:0] want_jk [23];
        int  idx;
        int  f_edge;
        logic acc;
        logic want_done;
        ops  = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b10};
        lens = '{4'd3, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        want_jk = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                    2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00,
                    2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00,
                    2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        idx = 0; f_edge = -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = ops[0]; cmd_len = lens[0];
        for (int c = 0; c <= 22; c++) begin
            acc = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            if (acc) begin
                if (idx == 5) f_edge = c;
                idx++;
                if (idx < 6) begin
                    cmd_op = ops[idx]; cmd_len = lens[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
            checks++; if ({J, K} !== want_jk[c]) begin
                errors++; $display("FAIL full_jk cyc %0d got %b want %b", c, {J, K}, want_jk[c]);
            end
            want_done = (c >= 6) && ((c - 6) % 3 == 0);
            checks++; if (done !== want_done) begin
                errors++; $display("FAIL full_done cyc %0d got %b want %b", c, done, want_done);
            end
            if (c == 4 || c == 5) begin
                checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low cyc %0d got %b want 0", c, cmd_ready); end
            end
            if (c == 6) begin
                checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_high cyc %0d got %b want 1", c, cmd_ready); end
            end
        end
        cmd_valid = 1'b0;
        checks++; if (f_edge !== 7) begin errors++; $display("FAIL full_fifth_accept got edge %0d want 7", f_edge); end
        checks++; if (idx !== 6) begin errors++; $display("FAIL full_accept_count got %0d want 6", idx); end
        checks++; if (exp_q !== 1'b1) begin errors++; $display("FAIL full_exp_q got %b want 1", exp_q); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL full_mismatch got %b want 0", mismatch); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy got %b want 0", busy); end
    endtask

    task automatic test_mismatch();
        force_q0 = 1'b1;
        test_single("mm_set", 2'b10, 4'd0, 1'b1, 1'b1);
        force_q0 = 1'b0;
        test_single("mm_sticky", 2'b11, 4'd0, 1'b0, 1'b1);
        test_single("mm_sticky2", 2'b10, 4'd1, 1'b1, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mm_cleared got %b want 0", mismatch); end
        checks++; if (exp_q !== 1'b0) begin errors++; $display("FAIL mm_reset_exp_q got %b want 0", exp_q); end
    endtask

    task automatic test_reset_mid_drive();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 4'd7;
        @(posedge clk); #1;
        cmd_op = 2'b10; cmd_len = 4'd1;
        @(posedge clk); #1;
        cmd_op = 2'b01; cmd_len = 4'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({J, K} !== 2'b11) begin errors++; $display("FAIL mid_drive_jk got %b want 11", {J, K}); end
        checks++; if (exp_q !== 1'b1) begin errors++; $display("FAIL mid_drive_exp_q got %b want 1", exp_q); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_drive_busy got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({J, K} !== 2'b00) begin errors++; $display("FAIL abort_jk got %b want 00", {J, K}); end
        checks++; if (exp_q !== 1'b0) begin errors++; $display("FAIL abort_exp_q got %b want 0", exp_q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", cmd_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++; if ({J, K, done, busy} !== 4'b0000) begin
                errors++; $display("FAIL abort_quiet cyc %0d jk_done_busy got %b want 0000", c, {J, K, done, busy});
            end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 4'd0; force_q0 = 1'b0;
        test_reset();
        test_single("set_len2", 2'b10, 4'd2, 1'b1, 1'b0);
        test_toggle();
        test_full_fifo();
        test_mismatch();
        test_reset_mid_drive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_cmd_seq.md
# jk_cmd_seq

Command sequencer that sits directly upstream of the JK latch stage. It accepts queued J/K commands over a valid/ready handshake and drives the latch's J and K inputs for a programmed number of clock cycles. It also maintains a cycle-accurate model of the expected latch output and checks the latch's q feedback after every command. This replaces hand-timed J/K stimulus with a repeatable, self-checking driver.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries (power of two, ≥2)
- CNT_W, 4: width of per-command cycle count

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_op  in  2  {J,K} value: 00 hold, 01 reset, 10 set, 11 toggle
- cmd_len  in  CNT_W  drive duration minus one; drives for cmd_len+1 cycles
- J  out  1  registered J to latch
- K  out  1  registered K to latch
- q  in  1  latch output feedback
- busy  out  1  state != IDLE or FIFO non-empty
- exp_q  out  1  modelled latch output
- done  out  1  one-cycle pulse per completed command
- mismatch  out  1  sticky; set when sampled q != exp_q

## Operation
- Handshake: push on the rising edge where cmd_valid && cmd_ready. {cmd_op, cmd_len} is captured into the FIFO. While cmd_valid=1 and cmd_ready=0, no push occurs.
- State machine: IDLE, DRIVE, CHECK.
  - IDLE: J=K=0. If the FIFO is non-empty: pop the head, load op/len into cnt, and go to DRIVE.
  - DRIVE: {J,K}=op. On each edge, update exp_q:
    - hold: unchanged
    - reset: 0
    - set: 1
    - toggle: ~exp_q
  - DRIVE exit: when cnt==0, go to CHECK; otherwise cnt decrements.
  - CHECK: J=K=0. On the exit edge:
    - compare q with exp_q; on inequality set mismatch
    - pulse done
    - if the FIFO is non-empty, pop and go to DRIVE; else go to IDLE.
- Toggle with cmd_len=n flips exp_q exactly n+1 times.
- The FIFO is a standard circular buffer with wrap-around pointers.
  - Push when full: impossible, because cmd_ready is low.
  - Pop when empty: never issued.
  - Simultaneous push and pop: allowed at any occupancy below full; occupancy is unchanged.
- The latch's own active-low reset is driven as ~rst at the system top. exp_q and the latch therefore both restart at 0.

## Timing
- Reset values (rst=1 at an edge): state IDLE, FIFO empty, cnt 0, J=0, K=0, exp_q=0, mismatch=0, done=0, busy=0, cmd_ready=1.
- rst mid-command: drive aborts at that edge and queued commands are discarded. No done pulse for the aborted command.
- Latency from idle: accept at edge E → J/K valid after edge E+1 → held through cmd_len+1 cycles → CHECK cycle → done high in the cycle after edge E+cmd_len+3.
- Back-to-back commands: exactly one J=K=0 cycle (CHECK) separates consecutive drives. Throughput is one command per cmd_len+2 cycles.
- cmd_ready reflects registered occupancy. Freeing a slot by pop raises cmd_ready on the following cycle.
- q is sampled only on the CHECK exit edge and is ignored at all other times.

## Structure
- Shared package jk_pkg holds:
  - op encoding constants: OP_HOLD=2'b00, OP_RST=2'b01, OP_SET=2'b10, OP_TOG=2'b11
  - state encoding: IDLE, DRIVE, CHECK
- Sub-module jk_cmd_fifo: a synchronous FIFO of DEPTH × (2+CNT_W).
  - Ports: clk, rst, push, pop, wdata, rdata, full, empty.
  - Sequencer FSM and exp_q model stay in jk_cmd_seq.

## Test plan
- Reset: hold rst=1 for 2 cycles with cmd_valid=1 → J=K=0, exp_q=0, cmd_ready=1, nothing queued after rst drops.
- Single set: push op=10 len=2 with the latch connected → J=1,K=0 for 3 cycles, then CHECK with q=1, exp_q=1, done pulse, mismatch=0.
- Toggle count: from exp_q=0, push op=11 len=2 → exp_q ends at 1 (3 flips). Push op=11 len=1 → exp_q ends at 1 (2 flips).
- Full FIFO: push 5 commands while the first drives with DEPTH=4.
  - cmd_ready drops once 4 are queued.
  - The 5th is accepted only after the next pop.
  - Commands execute in order with exactly one idle cycle between drives.
- Mismatch: force q=0 during CHECK of a set command → mismatch=1 and stays 1 through later good commands until rst.
- Reset mid-drive: assert rst during DRIVE of op=11 len=7 with 2 queued → next cycle J=K=0, exp_q=0, FIFO empty, no done pulse.
